// File: rtl/iq_avg_snapshot_ctrl_pkg.sv
// Shared constants and types for the IQ-average snapshot capture sequencer.
package iq_avg_snapshot_ctrl_pkg;

  // Control word bit positions
  localparam int unsigned START_B  = 0;
  localparam int unsigned WSYNC_B  = 1;
  localparam int unsigned ABORT_B  = 2;
  localparam int unsigned AVG_LSB  = 4;
  localparam int unsigned LAST_LSB = 16;

  // Status word bit positions
  localparam int unsigned ST_BUSY_B    = 0;
  localparam int unsigned ST_DONE_B    = 1;
  localparam int unsigned ST_ABORTED_B = 2;
  localparam int unsigned ST_WORDS_LSB = 16;

  // Largest averaging exponent; also the accumulator headroom in bits
  localparam int unsigned MAX_AVG_LOG2 = 8;

  typedef enum logic [1:0] {
    StIdle,
    StWaitSync,
    StCapture,
    StDone
  } state_e;

  function automatic logic [3:0] clamp_log2(input logic [3:0] v);
    return (v > 4'(MAX_AVG_LOG2)) ? 4'(MAX_AVG_LOG2) : v;
  endfunction

endpackage

// File: rtl/iq_avg_snapshot_ctrl_if.sv
// Snapshot BRAM write port: address, {avg_i, avg_q} data and write strobe.
interface iq_avg_snapshot_ctrl_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10
);
  logic [ADDR_W-1:0]   bram_addr;
  logic [2*DATA_W-1:0] bram_data;
  logic                bram_we;

  modport master (output bram_addr, output bram_data, output bram_we);
  modport slave  (input  bram_addr, input  bram_data, input  bram_we);
endinterface

// File: rtl/iq_avg_snapshot_ctrl_iq_sum_shift.sv
// I/Q accumulate-and-average datapath: sums 2^log2 samples and presents the
// arithmetically shifted sum on the sample that completes a word.
module iq_sum_shift
  import iq_avg_snapshot_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     sample_en,
  input  logic [3:0]               log2,
  input  logic signed [DATA_W-1:0] in_i,
  input  logic signed [DATA_W-1:0] in_q,
  output logic                     word_done,
  output logic [DATA_W-1:0]        avg_i,
  output logic [DATA_W-1:0]        avg_q
);

  localparam int unsigned ACC_W = DATA_W + MAX_AVG_LOG2;

  logic signed [ACC_W-1:0] acc_i_q, acc_q_q;
  logic signed [ACC_W-1:0] sum_i, sum_q, shift_i, shift_q;
  logic [8:0]              cnt_q;
  logic [8:0]              target;
  logic                    unused_hi;

  // Sum includes the current sample so the completing sample is averaged in
  always_comb begin
    sum_i     = acc_i_q + ACC_W'(in_i);
    sum_q     = acc_q_q + ACC_W'(in_q);
    shift_i   = sum_i >>> log2;
    shift_q   = sum_q >>> log2;
    target    = (9'd1 << log2) - 9'd1;
    word_done = sample_en && (cnt_q == target);
    avg_i     = shift_i[DATA_W-1:0];
    avg_q     = shift_q[DATA_W-1:0];
    unused_hi = ^{shift_i[ACC_W-1:DATA_W], shift_q[ACC_W-1:DATA_W]};
  end

  // Accumulators and sample counter; cleared after each completed word
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_i_q <= '0;
      acc_q_q <= '0;
      cnt_q   <= '0;
    end else if (sample_en) begin
      if (word_done) begin
        acc_i_q <= '0;
        acc_q_q <= '0;
        cnt_q   <= '0;
      end else begin
        acc_i_q <= sum_i;
        acc_q_q <= sum_q;
        cnt_q   <= cnt_q + 9'd1;
      end
    end
  end

endmodule

// File: rtl/iq_avg_snapshot_ctrl.sv
// Capture sequencer: on a software start edge, averages 2^L IQ samples per
// word, writes last_addr+1 words to the snapshot BRAM and reports status.
module iq_avg_snapshot_ctrl
  import iq_avg_snapshot_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                     user_clk,
  input  logic                     user_rst,
  input  logic [31:0]              ctrl_word,
  input  logic                     sync_in,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_i,
  input  logic signed [DATA_W-1:0] in_q,
  iq_avg_snapshot_ctrl_if.master   bram,
  output logic [31:0]              status
);

  state_e              state_q;
  logic                start_q;
  logic [3:0]          l_q;
  logic [ADDR_W-1:0]   last_q;
  logic [ADDR_W:0]     words_q;
  logic                busy_q, done_q, aborted_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2*DATA_W-1:0] data_q;
  logic                we_q;

  logic                start_edge, abort_req, sample_en, dp_clear, word_done;
  logic [DATA_W-1:0]   avg_i, avg_q;
  logic                unused_ctrl;

  // Control decode; abort suppresses counting so no partial word lands
  always_comb begin
    start_edge  = ctrl_word[START_B] & ~start_q;
    abort_req   = ctrl_word[ABORT_B];
    sample_en   = (state_q == StCapture) && in_valid && !abort_req;
    dp_clear    = (state_q != StCapture);
    unused_ctrl = ^{ctrl_word[3], ctrl_word[15:8], ctrl_word[31:LAST_LSB+ADDR_W]};
  end

  iq_sum_shift #(
    .DATA_W (DATA_W)
  ) u_sum (
    .clk       (user_clk),
    .rst       (user_rst),
    .clear     (dp_clear),
    .sample_en (sample_en),
    .log2      (l_q),
    .in_i      (in_i),
    .in_q      (in_q),
    .word_done (word_done),
    .avg_i     (avg_i),
    .avg_q     (avg_q)
  );

  // Sequencer FSM with registered BRAM port and status flags
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q   <= StIdle;
      start_q   <= 1'b1;  // a start bit held through reset is not an edge
      l_q       <= '0;
      last_q    <= '0;
      words_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
    end else begin
      start_q <= ctrl_word[START_B];
      we_q    <= 1'b0;
      if (abort_req) begin
        state_q   <= StIdle;
        aborted_q <= aborted_q | busy_q;
        busy_q    <= 1'b0;
        done_q    <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle, StDone: begin
            if (start_edge) begin
              state_q   <= ctrl_word[WSYNC_B] ? StWaitSync : StCapture;
              l_q       <= clamp_log2(ctrl_word[AVG_LSB +: 4]);
              last_q    <= ctrl_word[LAST_LSB +: ADDR_W];
              words_q   <= '0;
              busy_q    <= 1'b1;
              done_q    <= 1'b0;
              aborted_q <= 1'b0;
            end
          end
          StWaitSync: begin
            if (sync_in) state_q <= StCapture;
          end
          StCapture: begin
            if (word_done) begin
              we_q    <= 1'b1;
              addr_q  <= words_q[ADDR_W-1:0];
              data_q  <= {avg_i, avg_q};
              words_q <= words_q + (ADDR_W+1)'(1);
              if (words_q[ADDR_W-1:0] == last_q) begin
                state_q <= StDone;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Status word assembled from registered flags
  always_comb begin
    status                            = '0;
    status[ST_BUSY_B]                 = busy_q;
    status[ST_DONE_B]                 = done_q;
    status[ST_ABORTED_B]              = aborted_q;
    status[ST_WORDS_LSB +: ADDR_W+1]  = words_q;
  end

  assign bram.bram_addr = addr_q;
  assign bram.bram_data = data_q;
  assign bram.bram_we   = we_q;

endmodule

// File: tb/tb_iq_avg_snapshot_ctrl.sv
// Directed bench for the IQ-average snapshot sequencer.
module tb_iq_avg_snapshot_ctrl;

  logic               user_clk = 1'b0;
  logic               user_rst;
  logic [31:0]        ctrl_word;
  logic               sync_in;
  logic               in_valid;
  logic signed [15:0] in_i, in_q;
  logic [31:0]        status;

  int n_checks = 0;
  int n_fail   = 0;

  iq_avg_snapshot_ctrl_if #(.DATA_W(16), .ADDR_W(10)) bram_if ();

  iq_avg_snapshot_ctrl #(
    .DATA_W (16),
    .ADDR_W (10)
  ) dut (
    .user_clk  (user_clk),
    .user_rst  (user_rst),
    .ctrl_word (ctrl_word),
    .sync_in   (sync_in),
    .in_valid  (in_valid),
    .in_i      (in_i),
    .in_q      (in_q),
    .bram      (bram_if),
    .status    (status)
  );

  always #5 user_clk = ~user_clk;

  typedef struct packed {
    logic [3:0]       l;
    logic [3:0][15:0] si;
    logic [3:0][15:0] sq;
    logic [15:0]      ei;
    logic [15:0]      eq;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(negedge user_clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_ctrl(input logic st, input logic ws, input logic ab,
                                          input logic [3:0] l, input logic [9:0] last);
    logic [31:0] w;
    w        = '0;
    w[0]     = st;
    w[1]     = ws;
    w[2]     = ab;
    w[7:4]   = l;
    w[25:16] = last;
    return w;
  endfunction

  function automatic logic [31:0] mk_status(input logic busy, input logic done,
                                            input logic ab, input logic [10:0] words);
    logic [31:0] s;
    s        = '0;
    s[0]     = busy;
    s[1]     = done;
    s[2]     = ab;
    s[26:16] = words;
    return s;
  endfunction

  task automatic drive(input logic v, input logic [15:0] i, input logic [15:0] q);
    in_valid = v;
    in_i     = i;
    in_q     = q;
  endtask

  // Leaves the bench at the negedge after the start edge was sampled
  task automatic start_cap(input logic ws, input logic [3:0] l, input logic [9:0] last);
    drive(1'b0, 16'd0, 16'd0);
    sync_in   = 1'b0;
    ctrl_word = mk_ctrl(1'b0, ws, 1'b0, l, last);
    step();
    ctrl_word = mk_ctrl(1'b1, ws, 1'b0, l, last);
    step();
  endtask

  initial begin
    int n;
    int early;

    vecs[0] = '{l: 4'd2, si: {16'sd5, 16'sd3, 16'sd2, 16'sd1},
                sq: {-16'sd2, -16'sd1, -16'sd1, -16'sd1}, ei: 16'sd2, eq: -16'sd2};
    vecs[1] = '{l: 4'd0, si: {16'sd0, 16'sd0, 16'sd0, 16'sd7},
                sq: {16'sd0, 16'sd0, 16'sd0, -16'sd3}, ei: 16'sd7, eq: -16'sd3};
    vecs[2] = '{l: 4'd1, si: {16'sd0, 16'sd0, 16'sd4, 16'sd3},
                sq: {16'sd0, 16'sd0, -16'sd4, -16'sd3}, ei: 16'sd3, eq: -16'sd4};
    vecs[3] = '{l: 4'd2, si: {16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767},
                sq: {16'h8000, 16'h8000, 16'h8000, 16'h8000}, ei: 16'sd32767, eq: 16'h8000};
    vecs[4] = '{l: 4'd1, si: {16'sd0, 16'sd0, 16'sd0, -16'sd1},
                sq: {16'sd0, 16'sd0, 16'sd0, 16'sd1}, ei: -16'sd1, eq: 16'sd0};
    vecs[5] = '{l: 4'd2, si: {16'sd100, -16'sd100, 16'sd50, -16'sd51},
                sq: {16'sd3, 16'sd3, 16'sd3, 16'sd2}, ei: -16'sd1, eq: 16'sd2};

    // Reset with the start bit held high
    user_rst  = 1'b1;
    sync_in   = 1'b0;
    ctrl_word = mk_ctrl(1'b1, 1'b0, 1'b0, 4'd0, 10'd3);
    drive(1'b1, 16'd1, 16'd1);
    repeat (3) step();
    chk("rst_we", bram_if.bram_we, 0);
    chk("rst_addr", bram_if.bram_addr, 0);
    chk("rst_data", bram_if.bram_data, 0);
    chk("rst_status", status, 0);
    user_rst = 1'b0;
    early = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      early += int'(bram_if.bram_we);
    end
    chk("held_start_no_we", early, 0);
    chk("held_start_status", status, 0);

    // L=0, last_addr=3, continuous valid; a second edge mid-capture is ignored
    start_cap(1'b0, 4'd0, 10'd3);
    chk("a_busy", status, mk_status(1'b1, 1'b0, 1'b0, 11'd0));
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 16'(k), 16'(-k));
      if (k == 1) ctrl_word = mk_ctrl(1'b0, 1'b0, 1'b0, 4'd0, 10'd3);
      if (k == 2) ctrl_word = mk_ctrl(1'b1, 1'b0, 1'b0, 4'd0, 10'd3);
      step();
      chk("a_we", bram_if.bram_we, 1);
      chk("a_addr", bram_if.bram_addr, 64'(k - 1));
      chk("a_data", bram_if.bram_data, {16'(k), 16'(-k)});
      chk("a_status", status, (k < 4) ? mk_status(1'b1, 1'b0, 1'b0, 11'(k))
                                      : mk_status(1'b0, 1'b1, 1'b0, 11'd4));
    end
    early = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      early += int'(bram_if.bram_we);
    end
    chk("a_no_extra_we", early, 0);
    chk("a_done_sticky", status, mk_status(1'b0, 1'b1, 1'b0, 11'd4));

    // Table of single-word averages
    for (int v = 0; v < 6; v++) begin
      start_cap(1'b0, vecs[v].l, 10'd0);
      chk("t_busy", status, mk_status(1'b1, 1'b0, 1'b0, 11'd0));
      n = 1 << vecs[v].l;
      for (int k = 0; k < n; k++) begin
        drive(1'b1, vecs[v].si[k], vecs[v].sq[k]);
        step();
        if (k < n - 1) chk("t_we_early", bram_if.bram_we, 0);
      end
      drive(1'b0, 16'd0, 16'd0);
      chk("t_we", bram_if.bram_we, 1);
      chk("t_addr", bram_if.bram_addr, 0);
      chk("t_data", bram_if.bram_data, {vecs[v].ei, vecs[v].eq});
      chk("t_status", status, mk_status(1'b0, 1'b1, 1'b0, 11'd1));
      step();
      chk("t_we_once", bram_if.bram_we, 0);
    end

    // avg_log2=15 clamps to 8: one word per 256 samples
    start_cap(1'b0, 4'd15, 10'd0);
    early = 0;
    for (int k = 0; k < 256; k++) begin
      drive(1'b1, 16'sd2, -16'sd2);
      step();
      if (k < 255) early += int'(bram_if.bram_we);
    end
    drive(1'b0, 16'd0, 16'd0);
    chk("clamp_early", early, 0);
    chk("clamp_we", bram_if.bram_we, 1);
    chk("clamp_data", bram_if.bram_data, {16'sd2, -16'sd2});

    // wait_sync: valid samples before and during the sync cycle are not counted
    start_cap(1'b1, 4'd0, 10'd1);
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 16'sd4, 16'sd4);
      step();
      chk("ws_no_we", bram_if.bram_we, 0);
      chk("ws_busy", status, mk_status(1'b1, 1'b0, 1'b0, 11'd0));
    end
    sync_in = 1'b1;
    drive(1'b1, 16'sd9, 16'sd9);
    step();
    sync_in = 1'b0;
    chk("ws_sync_cycle", bram_if.bram_we, 0);
    drive(1'b1, 16'sd10, 16'sd1);
    step();
    chk("ws_we0", bram_if.bram_we, 1);
    chk("ws_data0", bram_if.bram_data, {16'sd10, 16'sd1});
    drive(1'b1, 16'sd11, 16'sd2);
    step();
    chk("ws_addr1", bram_if.bram_addr, 1);
    chk("ws_data1", bram_if.bram_data, {16'sd11, 16'sd2});
    chk("ws_done", status, mk_status(1'b0, 1'b1, 1'b0, 11'd2));

    // Abort after 2 of 4 words, on a cycle whose sample would finish word 3
    start_cap(1'b0, 4'd1, 10'd3);
    drive(1'b1, 16'sd1, 16'sd1); step();
    drive(1'b1, 16'sd3, 16'sd3); step();
    chk("ab_data0", bram_if.bram_data, {16'sd2, 16'sd2});
    drive(1'b1, 16'sd2, 16'sd0); step();
    drive(1'b1, 16'sd2, 16'sd0); step();
    chk("ab_words2", status, mk_status(1'b1, 1'b0, 1'b0, 11'd2));
    drive(1'b1, 16'sd5, 16'sd5); step();
    chk("ab_partial", bram_if.bram_we, 0);
    ctrl_word = mk_ctrl(1'b1, 1'b0, 1'b1, 4'd1, 10'd3);
    drive(1'b1, 16'sd7, 16'sd7);
    step();
    chk("ab_we", bram_if.bram_we, 0);
    chk("ab_status", status, mk_status(1'b0, 1'b0, 1'b1, 11'd2));
    ctrl_word = mk_ctrl(1'b1, 1'b0, 1'b0, 4'd1, 10'd3);
    early = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      early += int'(bram_if.bram_we);
    end
    chk("ab_no_we_after", early, 0);
    chk("ab_status_hold", status, mk_status(1'b0, 1'b0, 1'b1, 11'd2));

    // Abort wins over a simultaneous start edge
    ctrl_word = mk_ctrl(1'b0, 1'b0, 1'b0, 4'd0, 10'd3);
    step();
    ctrl_word = mk_ctrl(1'b1, 1'b0, 1'b1, 4'd0, 10'd3);
    step();
    ctrl_word = mk_ctrl(1'b1, 1'b0, 1'b0, 4'd0, 10'd3);
    step();
    chk("ab_prio", status, mk_status(1'b0, 1'b0, 1'b1, 11'd2));

    // Reset on a cycle whose sample would produce a write
    start_cap(1'b0, 4'd0, 10'd3);
    drive(1'b1, 16'sd5, 16'sd6);
    step();
    chk("rr_we0", bram_if.bram_data, {16'sd5, 16'sd6});
    drive(1'b1, 16'sd7, 16'sd8);
    user_rst = 1'b1;
    step();
    chk("rr_we", bram_if.bram_we, 0);
    chk("rr_addr", bram_if.bram_addr, 0);
    chk("rr_data", bram_if.bram_data, 0);
    chk("rr_status", status, 0);
    user_rst  = 1'b0;
    ctrl_word = '0;
    drive(1'b0, 16'd0, 16'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
